// File: rtl/spi_dac_receiver.sv
// spi_dac_receiver: MCP4911-style SPI DAC responder; deserializes 16-bit write frames and loads them on LD.
module spi_dac_receiver #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              dac_sck,
    input  logic              dac_sdi,
    input  logic              dac_cs,
    input  logic              dac_ld,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        config_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic [15:0]       frame_cnt,
    output logic              busy
);
    localparam int HOLD_W = FRAME_BITS - 2;
    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_MAX  = 5'(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sck_sync_q, sdi_sync_q, cs_sync_q, ld_sync_q;
    logic                    sck_prev_q, cs_prev_q, ld_prev_q;
    logic [4:0]              cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]   sh_q, sh_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    pend_q, pend_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [3:0]              cfg_q, cfg_d;
    logic                    valid_q, valid_d, err_q, err_d;
    logic [15:0]             fcnt_q, fcnt_d;
    logic                    sck_s, sdi_s, cs_s, ld_s;
    logic                    sck_rise, cs_fall, cs_rise, ld_fall, load;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign ld_s     = ld_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign ld_fall  = ~ld_s & ld_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        data_d  = data_q;
        cfg_d   = cfg_q;
        fcnt_d  = fcnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (cnt_q == CNT_FULL && !sh_q[FRAME_BITS-1]) begin
                        hold_d  = sh_q[FRAME_BITS-1:2];
                        pend_d  = 1'b1;
                        state_d = HOLD;
                        load    = ld_fall;
                    end else begin
                        err_d   = 1'b1;
                        state_d = pend_q ? HOLD : IDLE;
                    end
                end else begin
                    if (sck_rise) begin
                        sh_d  = {sh_q[FRAME_BITS-2:0], sdi_s};
                        cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 5'd1;
                    end
                    err_d = ld_fall;
                end
            end
            default: begin
                load = ld_fall;
                if (cs_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
        endcase
        // A load in the same cycle as a new cs fall must not swallow the new frame.
        if (load) begin
            data_d  = hold_d[DATA_W-1:0];
            cfg_d   = hold_d[HOLD_W-1 -: 4];
            valid_d = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            pend_d  = 1'b0;
            state_d = (state_d == SHIFT) ? SHIFT : IDLE;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '1;
            ld_sync_q  <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            ld_prev_q  <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            data_q     <= '0;
            cfg_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], dac_sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], dac_sdi};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], dac_cs};
            ld_sync_q  <= {ld_sync_q[SYNC_STAGES-2:0], dac_ld};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
            ld_prev_q  <= ld_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
            cfg_q      <= cfg_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign data_out   = data_q;
    assign config_out = cfg_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign frame_cnt  = fcnt_q;
    assign busy       = (state_q == SHIFT);
endmodule
